// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (issue logic, response consumers and the ALU itself).
interface alu_arbiter_if;
    // Requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_opcode;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [4:0]  req0_shamt;
    // Requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_opcode;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic [4:0]  req1_shamt;
    // Responses (payload shared by both requesters)
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_overflow;
    // Shared combinational ALU
    logic [4:0]  alu_opcode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ovf_add;
    logic        alu_ovf_sub;
    // Status
    logic        busy;

    modport slave (
        input  req0_valid, req0_opcode, req0_op1, req0_op2, req0_shamt,
        input  req1_valid, req1_opcode, req1_op1, req1_op2, req1_shamt,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_overflow,
        input  rsp0_ready, rsp1_ready,
        output alu_opcode, alu_op1, alu_op2, alu_shamt,
        input  alu_result, alu_zero, alu_ovf_add, alu_ovf_sub,
        output busy
    );

    modport master (
        output req0_valid, req0_opcode, req0_op1, req0_op2, req0_shamt,
        output req1_valid, req1_opcode, req1_op1, req1_op2, req1_shamt,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_overflow,
        output rsp0_ready, rsp1_ready,
        input  alu_opcode, alu_op1, alu_op2, alu_shamt,
        output alu_result, alu_zero, alu_ovf_add, alu_ovf_sub,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU; mul/div get SLOW_WAIT extra settle
// cycles; result and flags are registered and held until the winner takes them.
module alu_arbiter #(
    parameter int unsigned SLOW_WAIT = 4   // 0..15
) (
    input  logic         clock,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [3:0] SLOW_CNT = 4'(SLOW_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic        gid_q,        gid_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [4:0]  opcode_q,     opcode_d;
    logic [31:0] op1_q,        op1_d;
    logic [31:0] op2_q,        op2_d;
    logic [4:0]  shamt_q,      shamt_d;
    logic [31:0] result_q,     result_d;
    logic        zero_q,       zero_d;
    logic        ovf_q,        ovf_d;
    logic [1:0]  rsp_valid_q,  rsp_valid_d;

    // Combinational helpers
    logic [1:0]  req_ready;
    logic        sel;
    logic [4:0]  sel_opcode;
    logic        sel_ready;

    // Arbitration, operand capture, settle counting and response handshake.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        shamt_d      = shamt_q;
        result_d     = result_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = 2'b00;

        // Winner among the currently valid requesters; on a tie the one
        // that did not win last time.
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_grant_q;
        end else begin
            sel = bus.req1_valid;
        end
        sel_opcode = sel ? bus.req1_opcode : bus.req0_opcode;
        sel_ready  = gid_q ? bus.rsp1_ready : bus.rsp0_ready;

        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    req_ready[sel] = 1'b1;
                    opcode_d       = sel_opcode;
                    op1_d          = sel ? bus.req1_op1   : bus.req0_op1;
                    op2_d          = sel ? bus.req1_op2   : bus.req0_op2;
                    shamt_d        = sel ? bus.req1_shamt : bus.req0_shamt;
                    gid_d          = sel;
                    last_grant_d   = sel;
                    cnt_d          = (sel_opcode == OP_MUL || sel_opcode == OP_DIV)
                                     ? SLOW_CNT : 4'd0;
                    state_d        = S_EXEC;
                end
            end

            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d = bus.alu_result;
                    zero_d   = bus.alu_zero;
                    case (opcode_q)
                        OP_ADD:  ovf_d = bus.alu_ovf_add;
                        OP_SUB:  ovf_d = bus.alu_ovf_sub;
                        default: ovf_d = 1'b0;
                    endcase
                    rsp_valid_d[gid_q] = 1'b1;
                    state_d            = S_RESP;
                end
            end

            S_RESP: begin
                // Payload stays frozen; only the owner's ready releases it.
                if (rsp_valid_q[gid_q] && sel_ready) begin
                    rsp_valid_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any in-flight op.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            cnt_q        <= 4'd0;
            opcode_q     <= 5'd0;
            op1_q        <= 32'd0;
            op2_q        <= 32'd0;
            shamt_q      <= 5'd0;
            result_q     <= 32'd0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            cnt_q        <= cnt_d;
            opcode_q     <= opcode_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            shamt_q      <= shamt_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign bus.req0_ready   = req_ready[0];
    assign bus.req1_ready   = req_ready[1];
    assign bus.rsp0_valid   = rsp_valid_q[0];
    assign bus.rsp1_valid   = rsp_valid_q[1];
    assign bus.rsp_result   = result_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.alu_opcode   = opcode_q;
    assign bus.alu_op1      = op1_q;
    assign bus.alu_op2      = op2_q;
    assign bus.alu_shamt    = shamt_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule
